// File: rtl/astable_555.sv
// Cycle-counting 555 astable: FIRST_HIGH_COUNTS high, then LOW_COUNTS low / HIGH_COUNTS high forever.
// OUT follows the state one cycle after the deciding edge; free-running, no backpressure.
`timescale 1ns/1ps
module astable_555 #(
  parameter int HIGH_COUNTS       = 1000,
  parameter int LOW_COUNTS        = 1000,
  parameter int FIRST_HIGH_COUNTS = HIGH_COUNTS
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic ENA,
  output logic OUT,
  output logic OUT_N,
  output logic FALL
);

  localparam int MAX_HL     = (HIGH_COUNTS > LOW_COUNTS) ? HIGH_COUNTS : LOW_COUNTS;
  localparam int MAX_COUNTS = (MAX_HL > FIRST_HIGH_COUNTS) ? MAX_HL : FIRST_HIGH_COUNTS;
  localparam int CW         = $clog2(MAX_COUNTS + 1);

  localparam logic [CW-1:0] FIRST_END = CW'(FIRST_HIGH_COUNTS - 1);
  localparam logic [CW-1:0] HIGH_END  = CW'(HIGH_COUNTS - 1);
  localparam logic [CW-1:0] LOW_END   = CW'(LOW_COUNTS - 1);

  typedef enum logic [1:0] {IDLE, FIRST, LOW, HIGH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          out_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      out_q <= 1'b0;
    end else begin
      out_q <= OUT;
      // ENA low discharges the timer from any state, ahead of count end
      if (!ENA) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= FIRST;
            cnt   <= '0;
          end
          FIRST: begin
            if (cnt == FIRST_END) begin
              state <= LOW;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HIGH: begin
            if (cnt == HIGH_END) begin
              state <= LOW;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          LOW: begin
            if (cnt == LOW_END) begin
              state <= HIGH;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Pure state decode, so reset forces OUT low without waiting for an edge
  assign OUT   = (state == FIRST) || (state == HIGH);
  assign OUT_N = ~OUT;
  assign FALL  = out_q & ~OUT;

endmodule

// File: doc/astable_555.md
# astable_555

Emulates a 555 timer wired in astable (free-running) mode by counting clock cycles. It produces a rectangular wave with separately parameterised high and low times. The first high period after enable is longer, modelling the timing capacitor charging from 0 V rather than from 1/3 Vcc. It sits directly upstream of the `oneshot_555` stages in the discrete-logic game models: its active-low `OUT_N` / `FALL` outputs drive their negative-edge trigger inputs.

## Interface
- `HIGH_COUNTS`, default 1000: steady-state high time in CLK cycles; must be ≥1.
- `LOW_COUNTS`, default 1000: low time in CLK cycles; must be ≥1.
- `FIRST_HIGH_COUNTS`, default `HIGH_COUNTS`: first high time after enable, in cycles; must be ≥1.
- Counter width: `$clog2(max(HIGH_COUNTS, LOW_COUNTS, FIRST_HIGH_COUNTS) + 1)`, as a localparam.

Ports:
- `CLK` in 1: counting clock; all state changes on its rising edge.
- `RST_N` in 1: system reset; asynchronous assert, active-low.
- `ENA` in 1: models the 555 reset pin. High means run; low holds the timer off and discharges it. Sampled synchronously.
- `OUT` in/out: `OUT` out 1, the 555 output (high during charge).
- `OUT_N` out 1: always the inverse of `OUT`; suitable for direct connection to a oneshot `TRG_N`.
- `FALL` out 1: one-cycle strobe, high in the first cycle after `OUT` goes from 1 to 0.

## Operation
- States: `IDLE`, `FIRST` (first charge), `LOW` (discharge), `HIGH` (charge).
- `IDLE`:
  - `ENA`=1 → `FIRST`, with the counter cleared.
  - Otherwise stay in `IDLE`.
- `FIRST`:
  - `ENA`=0 → `IDLE`.
  - Else, counter == `FIRST_HIGH_COUNTS`-1 → `LOW`, counter cleared.
  - Else increment the counter.
- `HIGH`:
  - `ENA`=0 → `IDLE`.
  - Else, counter == `HIGH_COUNTS`-1 → `LOW`, counter cleared.
  - Else increment the counter.
- `LOW`:
  - `ENA`=0 → `IDLE`.
  - Else, counter == `LOW_COUNTS`-1 → `HIGH`, counter cleared.
  - Else increment the counter.
- `ENA`=0 has priority over count end in every state.
- A return to `IDLE` always clears the counter. The next enable therefore restarts from `FIRST`, because the capacitor is modelled as fully discharged.
- Outputs:
  - `OUT` = 1 iff state ∈ {`FIRST`, `HIGH`}. It is decoded from the state register, so it is glitch-free.
  - `OUT_N` = ~`OUT`.
  - `FALL` = `out_q` & ~`OUT`, where `out_q` is a register holding the previous cycle's `OUT`.
  - `FALL` fires both on the normal high→low transition and when `ENA` drops while `OUT` is high. `ENA` dropping while `OUT` is low produces no `FALL`.
- The counter never exceeds (active count − 1); no wrap-around is possible.

## Timing
- Reset (`RST_N`=0) takes effect immediately and holds for as long as it is asserted:
  - state `IDLE`, counter 0, `out_q` 0.
  - Outputs: `OUT`=0, `OUT_N`=1, `FALL`=0.
- Start latency: at the first rising edge where `ENA`=1 in `IDLE`, the state becomes `FIRST`. `OUT` rises in the following cycle.
- Waveform after start:
  - `OUT` high for exactly `FIRST_HIGH_COUNTS` cycles.
  - Then low for `LOW_COUNTS` cycles.
  - Then repeating: high for `HIGH_COUNTS`, low for `LOW_COUNTS`.
  - Steady-state period = `HIGH_COUNTS` + `LOW_COUNTS` cycles.
- Stop latency: at the first edge where `ENA`=0, the state becomes `IDLE`. `OUT` is 0 from that cycle on.
- `FALL` is high for exactly one cycle: the first cycle in which `OUT`=0 after a cycle with `OUT`=1.
- Count of 1: that phase lasts exactly one cycle. With all counts set to 1, `OUT` toggles every cycle after the first.
- Releasing `RST_N` with `ENA` already high starts at the first rising edge after release, following the normal `IDLE`→`FIRST` rule.

## Test plan
- Reset: assert `RST_N`=0 mid-`HIGH` → `OUT`=0, `OUT_N`=1, `FALL`=0 without waiting for a clock edge. Release with `ENA`=1 → `OUT` high for a full `FIRST_HIGH_COUNTS`.
- Waveform: `FIRST`=5, `HIGH`=3, `LOW`=2, `ENA` held 1. Expected `OUT` sequence: 1×5, 0×2, 1×3, 0×2, 1×3. `FALL`=1 in cycles 6, 11 and 16 (counting from the first `OUT`=1 cycle as cycle 1), and 0 everywhere else.
- Stop while high: same parameters, `ENA`→0 in the 2nd cycle of a `HIGH` phase → `OUT`=0 the next cycle and `FALL`=1 for one cycle. Re-enable 4 cycles later → high for 5 cycles (`FIRST`), not 3.
- Stop while low: `ENA`→0 during `LOW` → `OUT` stays 0 and `FALL` never asserts. Re-enable → `FIRST` phase of 5 cycles.
- Minimum counts: all counts = 1 → `OUT` alternates 1,0,1,0 and `FALL`=1 in every cycle where `OUT`=0 after a high cycle.
- Integration: connect `OUT_N` to `oneshot_555.TRG_N` with `COUNTS`=4, using `HIGH`=6 and `LOW`=10. The oneshot `OUT` should go high for 4 cycles, starting 2 cycles after each `astable_555` `OUT` rising edge, once per period of 16.
